// File: rtl/mul_sequencer_if.sv
// rtl/mul_sequencer_if.sv - decode/multiplier/writeback bundle for mul_sequencer
//
// master : decode stage and writeback arbiter (drives id_*, flush, wb_ack)
// slave  : mul_sequencer (drives mul_load, mul_step, mul_busy, stall, wb_req, wb_rd)
interface mul_sequencer_if;
   logic       id_valid;
   logic       mul_start;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       id_wr_regfile;
   logic       flush;
   logic       wb_ack;
   logic       mul_load;
   logic       mul_step;
   logic       mul_busy;
   logic       stall;
   logic       wb_req;
   logic [4:0] wb_rd;

   modport master (
      output id_valid, mul_start, id_rs, id_rt, id_rd, id_wr_regfile, flush, wb_ack,
      input  mul_load, mul_step, mul_busy, stall, wb_req, wb_rd
   );

   modport slave (
      input  id_valid, mul_start, id_rs, id_rt, id_rd, id_wr_regfile, flush, wb_ack,
      output mul_load, mul_step, mul_busy, stall, wb_req, wb_rd
   );
endinterface

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - issue and sequencing controller for the iterative multiplier
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : mul_sequencer_if.slave
//          in : id_valid, mul_start, id_rs, id_rt, id_rd, id_wr_regfile, flush, wb_ack
//          out: mul_load, mul_step, mul_busy, stall, wb_req, wb_rd
// Build option: MULSEQ_HAZARD_EN adds RAW/WAW stalls against the in-flight destination.
module mul_sequencer #(
   parameter int N_ITER = 16,
   parameter int CNT_W  = 5
) (
   input  logic           clk,
   input  logic           rst,
   mul_sequencer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [4:0]       pend_rd, pend_rd_nxt;
   logic             issue;
   logic             hazard;
   logic             stall_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         pend_rd <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         pend_rd <= pend_rd_nxt;
      end
   end

   // Outputs are forced low during reset, so a mul in decode cannot issue then.
   assign issue = (state == IDLE) && bus.id_valid && bus.mul_start && !bus.flush && !rst;

`ifdef MULSEQ_HAZARD_EN
   // r0 never holds a live result, so a pending write to it cannot hazard.
   assign hazard = (pend_rd != 5'd0) &&
                   ((bus.id_rs == pend_rd) || (bus.id_rt == pend_rd) ||
                    (bus.id_wr_regfile && (bus.id_rd == pend_rd)));
`else
   assign hazard = 1'b0;
`endif

   // The issuing mul itself never stalls; only younger decode instructions do.
   assign stall_c = (state != IDLE) && !rst && bus.id_valid && !bus.flush &&
                    (bus.mul_start || hazard);

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pend_rd_nxt = pend_rd;
      case (state)
         IDLE: begin
            if (issue) begin
               state_nxt   = RUN;
               cnt_nxt     = CNT_W'(N_ITER - 1);
               pend_rd_nxt = bus.id_rd;
            end
         end
         RUN: begin
            // cnt==0 is the final step cycle.
            if (cnt == '0) begin
               state_nxt = WB;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         WB: begin
            if (bus.wb_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.mul_load = issue;
   assign bus.mul_step = (state == RUN);
   assign bus.mul_busy = (state != IDLE);
   assign bus.stall    = stall_c;
   assign bus.wb_req   = (state == WB);
   assign bus.wb_rd    = pend_rd;
endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - self-checking bench for mul_sequencer
module tb_mul_sequencer;
   localparam int N_ITER = 16;
`ifdef MULSEQ_HAZARD_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mul_sequencer_if bus();

   mul_sequencer #(.N_ITER(N_ITER), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int         n;
      logic       r, v, ms;
      logic [4:0] rs, rt, rd;
      logic       wr, fl, ack;
      logic       e_load, e_step, e_busy, e_stall, e_req;
      logic [4:0] e_rd;
   } vec_t;

   vec_t tbl[$];

   int n_pass;
   int n_total;
   int cyc;

   // Reference model: a multiply is "age" cycles past its issue edge.
   bit         m_busy;
   int         m_age;
   logic [4:0] m_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
   endtask

   task automatic drive(input logic r, input logic v, input logic ms,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic wr, input logic fl, input logic ack);
      rst               = r;
      bus.id_valid      = v;
      bus.mul_start     = ms;
      bus.id_rs         = rs;
      bus.id_rt         = rt;
      bus.id_rd         = rd;
      bus.id_wr_regfile = wr;
      bus.flush         = fl;
      bus.wb_ack        = ack;
   endtask

   function automatic logic m_hazard();
      if (!HZ || m_rd == 5'd0) return 1'b0;
      return (bus.id_rs == m_rd) || (bus.id_rt == m_rd) ||
             (bus.id_wr_regfile && bus.id_rd == m_rd);
   endfunction

   task automatic check_model();
      logic e_load, e_stall;
      e_load  = !rst && !m_busy && bus.id_valid && bus.mul_start && !bus.flush;
      e_stall = !rst && m_busy && bus.id_valid && !bus.flush && (bus.mul_start || m_hazard());
      chk("mdl_load",  bus.mul_load, e_load);
      chk("mdl_step",  bus.mul_step, m_busy && m_age >= 1 && m_age <= N_ITER);
      chk("mdl_busy",  bus.mul_busy, m_busy);
      chk("mdl_stall", bus.stall,    e_stall);
      chk("mdl_req",   bus.wb_req,   m_busy && m_age > N_ITER);
      chk("mdl_rd",    bus.wb_rd,    m_rd);
   endtask

   task automatic model_update();
      if (rst) begin
         m_busy = 1'b0;
         m_age  = 0;
         m_rd   = 5'd0;
      end else if (!m_busy) begin
         if (bus.id_valid && bus.mul_start && !bus.flush) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_rd   = bus.id_rd;
         end
      end else if (m_age > N_ITER) begin
         if (bus.wb_ack) m_busy = 1'b0;
      end else begin
         m_age++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
   endtask

   task automatic add_row(input int n, input logic r, input logic v, input logic ms,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic wr, input logic fl, input logic ack,
                          input logic el, input logic es, input logic eb,
                          input logic est, input logic er, input logic [4:0] erd);
      vec_t t;
      t.n = n; t.r = r; t.v = v; t.ms = ms; t.rs = rs; t.rt = rt; t.rd = rd;
      t.wr = wr; t.fl = fl; t.ack = ack;
      t.e_load = el; t.e_step = es; t.e_busy = eb; t.e_stall = est; t.e_req = er; t.e_rd = erd;
      tbl.push_back(t);
   endtask

   // Holds the decode inputs until wb_req appears; latency is counted from the issue edge.
   task automatic wait_req(input string name, input logic v, input logic [4:0] rs,
                           input logic [4:0] exp_rd);
      int lat;
      lat = -1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         drive(1'b0, v, 1'b0, rs, rs, rs, 1'b1, 1'b0, 1'b1);
         #1;
         check_model();
         if (v) chk({name, "_nostall"}, bus.stall, 1'b0);
         if (bus.wb_req === 1'b1) begin
            lat = k;
            chk({name, "_rd"}, bus.wb_rd, exp_rd);
         end
         tick();
      end
      chk({name, "_lat"}, lat, N_ITER + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      cyc     = 0;
      m_busy  = 1'b0;
      m_age   = 0;
      m_rd    = 5'd0;
      drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tick();

      // n  r v ms rs rt rd wr fl ack | load step busy stall req rd
      add_row( 1, 1, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0);
      add_row( 1, 0, 1, 1, 1, 2, 5, 1, 0, 1,  1, 0, 0, 0,  0, 0);
      add_row( 2, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0,  0, 5);
      add_row(14, 0, 1, 0, 5, 0, 7, 1, 0, 1,  0, 1, 1, HZ, 0, 5);
      add_row( 1, 0, 1, 0, 5, 0, 7, 1, 0, 1,  0, 0, 1, HZ, 1, 5);
      add_row( 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 5);
      add_row( 1, 0, 1, 1, 0, 0, 9, 1, 0, 1,  1, 0, 0, 0,  0, 5);
      add_row( 1, 0, 1, 0, 9, 9, 9, 1, 1, 1,  0, 1, 1, 0,  0, 9);
      add_row(15, 0, 1, 1, 0, 0, 6, 1, 0, 1,  0, 1, 1, 1,  0, 9);
      add_row( 1, 0, 1, 1, 0, 0, 6, 1, 0, 1,  0, 0, 1, 1,  1, 9);
      add_row( 1, 0, 1, 1, 0, 0, 6, 1, 0, 1,  1, 0, 0, 0,  0, 9);
      add_row( 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, 1, 0,  0, 6);

      foreach (tbl[i]) begin
         for (int k = 0; k < tbl[i].n; k++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].ms, tbl[i].rs, tbl[i].rt, tbl[i].rd,
                  tbl[i].wr, tbl[i].fl, tbl[i].ack);
            #1;
            chk($sformatf("tbl%0d_load", i),  bus.mul_load, tbl[i].e_load);
            chk($sformatf("tbl%0d_step", i),  bus.mul_step, tbl[i].e_step);
            chk($sformatf("tbl%0d_busy", i),  bus.mul_busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_stall", i), bus.stall,    tbl[i].e_stall);
            chk($sformatf("tbl%0d_req", i),   bus.wb_req,   tbl[i].e_req);
            chk($sformatf("tbl%0d_rd", i),    bus.wb_rd,    tbl[i].e_rd);
            tick();
         end
      end

      // Back-to-back mul with write-port grant delayed to T+20.
      drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1; check_model(); tick();
      drive(1'b0, 1, 1, 0, 0, 5, 1, 0, 0);
      #1; check_model(); chk("A_issue1", bus.mul_load, 1'b1); tick();
      for (int c = 1; c <= 20; c++) begin
         drive(1'b0, 1, 1, 0, 0, 6, 1, 0, (c == 20));
         #1; check_model(); chk("A_stall", bus.stall, 1'b1); tick();
      end
      drive(1'b0, 1, 1, 0, 0, 6, 1, 0, 1);
      #1; check_model(); chk("A_issue2", bus.mul_load, 1'b1); tick();
      wait_req("A", 1'b0, 5'd0, 5'd6);

      // Reset during RUN aborts, then a fresh mul sequences normally.
      drive(1'b0, 1, 1, 0, 0, 4, 1, 0, 1);
      #1; check_model(); chk("B_issue1", bus.mul_load, 1'b1); tick();
      for (int k = 1; k <= 7; k++) begin
         drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
         #1; check_model(); tick();
      end
      drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 1);
      #1; check_model(); tick();
      drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1; check_model();
      chk("B_busy", bus.mul_busy, 1'b0);
      chk("B_step", bus.mul_step, 1'b0);
      chk("B_req",  bus.wb_req,   1'b0);
      chk("B_rd",   bus.wb_rd,    5'd0);
      tick();
      drive(1'b0, 1, 1, 0, 0, 3, 1, 0, 1);
      #1; check_model(); chk("B_issue2", bus.mul_load, 1'b1); tick();
      wait_req("B", 1'b0, 5'd0, 5'd3);

      // mul to r0 never hazards but still writes back.
      drive(1'b0, 1, 1, 0, 0, 0, 1, 0, 1);
      #1; check_model(); chk("C_issue", bus.mul_load, 1'b1); tick();
      wait_req("C", 1'b1, 5'd0, 5'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 63) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0,
               5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)),
               $urandom_range(0, 7) == 0,
               1'($urandom_range(0, 1)));
         #1; check_model(); tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Issue and sequencing controller for the iterative multiplier in the execute stage. It accepts a decoded `mul` from the decode stage and drives the multiplier's load and step strobes for a fixed iteration count. It then requests the shared register-file write port and stalls the front end on structural and register hazards against the in-flight multiply. It sits between the decode control word and the pipeline stall/writeback logic.

## Interface
- `N_ITER`, 16: multiplier iterations per operation; legal range 2..31.
- `CNT_W`, 5: iteration counter width; must satisfy N_ITER <= 2^CNT_W.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `id_valid`  in  1  decode-stage instruction valid.
- `mul_start`  in  1  decoded instruction is `mul`.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  decode-stage register fields (`id_rd` already remapped for I-type).
- `id_wr_regfile`  in  1  decode-stage instruction writes the register file.
- `flush`  in  1  taken branch or jump; kills the decode-stage instruction this cycle.
- `wb_ack`  in  1  write-port grant for the multiplier result.
- `mul_load`  out  1  one-cycle pulse; multiplier latches operands.
- `mul_step`  out  1  multiplier performs one iteration.
- `mul_busy`  out  1  state != IDLE.
- `stall`  out  1  hold PC and IF/ID; insert bubble into EX.
- `wb_req`  out  1  multiplier result ready for writeback.
- `wb_rd`  out  5  destination of the pending multiply.

## Operation
- State machine with three states:
  - IDLE: if `id_valid & mul_start & !flush`, assert `mul_load` (combinational, same cycle), latch `pend_rd <= id_rd`, load `cnt <= N_ITER-1`, and go to RUN. The issuing `mul` leaves decode without a stall.
  - RUN: `mul_step`=1 every cycle and `cnt` decrements. When `cnt==0`, go to WB (this is the last step cycle).
  - WB: `wb_req`=1 and `wb_rd`=`pend_rd`. On `wb_ack`, go to IDLE next cycle. Otherwise hold indefinitely.
- `wb_rd` is driven with `pend_rd` in all states and is meaningful only while `wb_req`=1.
- Stall conditions. When state != IDLE and `id_valid` and !`flush`, `stall`=1 if any of the following holds:
  - structural: `mul_start`;
  - RAW: `pend_rd`!=0 and (`id_rs`==`pend_rd` or `id_rt`==`pend_rd`);
  - WAW: `pend_rd`!=0 and `id_wr_regfile` and `id_rd`==`pend_rd`.
- `stall`=0 whenever state==IDLE.
- `flush` suppresses `stall` and issue for the decode-stage instruction only. An in-flight multiply is older than the branch and always completes and writes back.
- A `mul` to r0 runs and writes back normally, but never causes a hazard stall.
- A second `mul` stalled in decode issues from IDLE on the cycle after `wb_ack`.

## Timing
- Reset: state=IDLE, `cnt`=0, `pend_rd`=0. All outputs are 0, including `wb_rd`=0.
- Reset mid-operation: abort immediately with no writeback. Multiplier datapath contents are don't-care.
- Issue in cycle T:
  - `mul_load` is high in T.
  - `mul_step` is high in T+1 .. T+N_ITER (exactly N_ITER cycles).
  - `wb_req` rises in T+N_ITER+1.
  - With `wb_ack` in that same cycle, `mul_busy` falls in T+N_ITER+2. The earliest next issue is T+N_ITER+2.
- `wb_ack` is sampled only in WB. `wb_ack` in any other state is ignored.
- `stall` and `mul_load` are combinational from decode inputs and state. All other outputs are registered-state decodes.

## Configuration
- `MULSEQ_HAZARD_EN` defined: RAW and WAW stall terms are included, as specified above.
- Not defined: only the structural term (`mul_start` while busy) stalls. Software must not read or write `pend_rd` until N_ITER+2 cycles after issue. All other behaviour is identical.

## Test plan
- Reset, then `mul` with rd=5 at T, N_ITER=16, `wb_ack` held 1 → `mul_load` only at T; `mul_step` high for T+1..T+16; `wb_req`=1 with `wb_rd`=5 only at T+17; `mul_busy`=0 at T+18.
- `mul` rd=5, then `add` with rs=5 in decode at T+3 → `stall`=1 from T+3 through T+17. Without `MULSEQ_HAZARD_EN`, `stall`=0.
- Back-to-back `mul` rd=5 then `mul` rd=6, `wb_ack` delayed to T+20 → second `mul` stalled through T+20, `mul_load` at T+21, `wb_rd`=6 at T+38.
- `mul` in RUN with `flush`=1 and a hazarding instruction in decode → `stall`=0 that cycle; the in-flight `mul` still asserts `wb_req` at T+17.
- `rst` asserted at T+8 during RUN → all outputs 0 at T+9, no `wb_req`; a new `mul` at T+10 sequences normally.
- `mul` with rd=0, then `add` with rs=0 in decode → no stall; `wb_req` with `wb_rd`=0 at T+17.
